// File: rtl/ova_dvp_tx_pkg.sv
// Shared definitions for the OV-style DVP transmitter: frame FSM states,
// default sensor timing and a helper for sizing the line counter.
package ova_dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } ova_state_e;

    localparam int unsigned OVA_H_ACTIVE  = 640;
    localparam int unsigned OVA_H_BLANK   = 144;
    localparam int unsigned OVA_V_ACTIVE  = 480;
    localparam int unsigned OVA_VS_LINES  = 3;
    localparam int unsigned OVA_VBP_LINES = 17;
    localparam int unsigned OVA_VFP_LINES = 10;

    function automatic int unsigned max_lines(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ova_dvp_tx_if.sv
// Pixel-stream input and DVP output bundle of the transmitter.
interface ova_dvp_tx_if;
    logic [15:0] pix;
    logic        pix_vld;
    logic        pix_rdy;
    logic        pclk;
    logic [7:0]  data;
    logic        href;
    logic        vsync;

    modport master (output pix, pix_vld, input pix_rdy, pclk, data, href, vsync);
    modport slave  (input pix, pix_vld, output pix_rdy, pclk, data, href, vsync);
endinterface

// File: rtl/ova_dvp_tx_timing.sv
// Pixel-clock phase, horizontal/line counters and frame FSM. state/hcnt name
// the slot that the next launch will put on the bus.
module ova_dvp_tx_timing
    import ova_dvp_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = OVA_H_ACTIVE,
    parameter int unsigned H_BLANK   = OVA_H_BLANK,
    parameter int unsigned V_ACTIVE  = OVA_V_ACTIVE,
    parameter int unsigned VS_LINES  = OVA_VS_LINES,
    parameter int unsigned VBP_LINES = OVA_VBP_LINES,
    parameter int unsigned VFP_LINES = OVA_VFP_LINES,
    localparam int unsigned LT = 2 * H_ACTIVE + H_BLANK,
    localparam int unsigned HW = $clog2(LT),
    localparam int unsigned LW = $clog2(max_lines(V_ACTIVE, VS_LINES, VBP_LINES, VFP_LINES) + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          launch,
    output ova_state_e    state,
    output logic [HW-1:0] hcnt,
    output logic          frame_first
);

    logic          phase_r;
    logic [HW-1:0] hcnt_r, hcnt_s;
    logic [LW-1:0] lcnt_r, lcnt_s, last_s;
    ova_state_e    state_r, state_s, succ_s;

    // Last line index of the current region and the region that follows it
    always_comb begin
        last_s = '0;
        succ_s = ST_IDLE;
        case (state_r)
            ST_VSYNC:  begin last_s = LW'(VS_LINES - 1);  succ_s = ST_VBP;    end
            ST_VBP:    begin last_s = LW'(VBP_LINES - 1); succ_s = ST_ACTIVE; end
            ST_ACTIVE: begin last_s = LW'(V_ACTIVE - 1);  succ_s = ST_VFP;    end
            ST_VFP:    begin last_s = LW'(VFP_LINES - 1); succ_s = en ? ST_VSYNC : ST_IDLE; end
            default:   begin last_s = '0;                 succ_s = ST_IDLE;   end
        endcase
    end

    // Next slot; only advances on a launch clk
    always_comb begin
        state_s = state_r;
        hcnt_s  = hcnt_r;
        lcnt_s  = lcnt_r;
        if (phase_r) begin
            case (state_r)
                ST_IDLE: begin
                    hcnt_s  = '0;
                    lcnt_s  = '0;
                    state_s = en ? ST_VSYNC : ST_IDLE;
                end
                ST_VSYNC, ST_VBP, ST_ACTIVE, ST_VFP: begin
                    if (hcnt_r == HW'(LT - 1)) begin
                        hcnt_s = '0;
                        if (lcnt_r == last_s) begin
                            lcnt_s  = '0;
                            state_s = succ_s;
                        end else begin
                            lcnt_s = lcnt_r + LW'(1);
                        end
                    end else begin
                        hcnt_s = hcnt_r + HW'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    hcnt_s  = '0;
                    lcnt_s  = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Phase toggle and slot registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r <= 1'b0;
            hcnt_r  <= '0;
            lcnt_r  <= '0;
            state_r <= ST_IDLE;
        end else begin
            phase_r <= ~phase_r;
            hcnt_r  <= hcnt_s;
            lcnt_r  <= lcnt_s;
            state_r <= state_s;
        end
    end

    assign launch      = phase_r;
    assign state       = state_r;
    assign hcnt        = hcnt_r;
    assign frame_first = (state_r == ST_VSYNC) && (hcnt_r == '0) && (lcnt_r == '0);

endmodule

// File: rtl/ova_dvp_tx.sv
// DVP camera-port emulator: turns an RGB565 pixel stream into pclk/href/vsync
// plus 8-bit data, high byte first, all outputs registered.
module ova_dvp_tx
    import ova_dvp_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = OVA_H_ACTIVE,
    parameter int unsigned H_BLANK   = OVA_H_BLANK,
    parameter int unsigned V_ACTIVE  = OVA_V_ACTIVE,
    parameter int unsigned VS_LINES  = OVA_VS_LINES,
    parameter int unsigned VBP_LINES = OVA_VBP_LINES,
    parameter int unsigned VFP_LINES = OVA_VFP_LINES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          frame_start,
    output logic          underrun,
    ova_dvp_tx_if.slave   bus
);

    localparam int unsigned HW = $clog2(2 * H_ACTIVE + H_BLANK);

    logic          launch_s, frame_first_s, active_s, hi_s;
    ova_state_e    state_s;
    logic [HW-1:0] hcnt_s;
    logic [7:0]    data_r, lo_r;
    logic          href_r, vsync_r, rdy_r, frame_start_r, underrun_r;

    ova_dvp_tx_timing #(
        .H_ACTIVE (H_ACTIVE),  .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),  .VS_LINES (VS_LINES),
        .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .launch     (launch_s),
        .state      (state_s),
        .hcnt       (hcnt_s),
        .frame_first(frame_first_s)
    );

    assign active_s = (state_s == ST_ACTIVE) && (hcnt_s < HW'(2 * H_ACTIVE));
    assign hi_s     = active_s && !hcnt_s[0];

    // Byte mux, low-byte latch, ready and sticky underrun; rdy is raised the clk
    // before a high-byte launch so it is high exactly on that launch clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r        <= 8'h00;
            lo_r          <= 8'h00;
            href_r        <= 1'b0;
            vsync_r       <= 1'b0;
            rdy_r         <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else if (launch_s) begin
            vsync_r       <= (state_s == ST_VSYNC);
            href_r        <= active_s;
            frame_start_r <= frame_first_s;
            rdy_r         <= 1'b0;
            underrun_r    <= (hi_s && !bus.pix_vld) || (underrun_r && !frame_first_s);
            if (hi_s) begin
                data_r <= bus.pix_vld ? bus.pix[15:8] : 8'h00;
                lo_r   <= bus.pix_vld ? bus.pix[7:0]  : 8'h00;
            end else if (active_s) begin
                data_r <= lo_r;
            end else begin
                data_r <= 8'h00;
            end
        end else begin
            rdy_r         <= hi_s;
            frame_start_r <= 1'b0;
        end
    end

    assign bus.pclk    = launch_s;
    assign bus.data    = data_r;
    assign bus.href    = href_r;
    assign bus.vsync   = vsync_r;
    assign bus.pix_rdy = rdy_r;
    assign frame_start = frame_start_r;
    assign underrun    = underrun_r;

endmodule
